// File: rtl/regfile_multi.sv
// Multi-port register file: three combinational read ports, two prioritised write
// ports, optional bypass and zero register, with a post-reset clear/preload sweep.
module regfile_rport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);
  always_comb begin
    rdata = arr;
    if (!ready)                                     rdata = '0;
    else if (ZERO_REG && raddr == '0)               rdata = '0;
    else if (BYPASS && we1 && waddr1 == raddr)      rdata = wdata1;
    else if (BYPASS && we0 && waddr0 == raddr)      rdata = wdata0;
  end
endmodule

module regfile_multi #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter bit                ZERO_REG  = 1'b1,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_TOP1 = DATA_W'(2),
  parameter logic [DATA_W-1:0] INIT_TOP0 = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready,
  output logic              wr_drop,
  input  logic              wr_drop_clr
);
  localparam int              DEPTH = 2 ** ADDR_W;
  localparam int              NRP   = 3;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PREV = ADDR_W'(DEPTH - 2);

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sweep_val;
  logic [DATA_W-1:0] mem [DEPTH];
  wreq_t             wp0, wp1;

  logic [NRP-1:0][ADDR_W-1:0] raddr_v;
  logic [NRP-1:0][DATA_W-1:0] rdata_v;

  assign sweep_val = (idx == LAST) ? INIT_TOP0 :
                     (idx == PREV) ? INIT_TOP1 : '0;

  // Port 1 owns a shared address; address 0 is read-only when the zero register is on.
  always_comb begin
    wp1.en   = ready && we1 && !(ZERO_REG && waddr1 == '0);
    wp1.addr = waddr1;
    wp1.data = wdata1;
    wp0.en   = ready && we0 && !(ZERO_REG && waddr0 == '0) && !(we1 && waddr1 == waddr0);
    wp0.addr = waddr0;
    wp0.data = wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      idx     <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RUN:     ;
        default: state <= CLEAR;
      endcase
      if (!ready && (we0 || we1)) wr_drop <= 1'b1;
      else if (wr_drop_clr)       wr_drop <= 1'b0;
    end
  end

  // No reset on the array; an edge while reset is held only rewrites entry 0,
  // which the sweep overwrites before ready rises.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[idx] <= sweep_val;
    end else begin
      if (wp0.en) mem[wp0.addr] <= wp0.data;
      if (wp1.en) mem[wp1.addr] <= wp1.data;
    end
  end

  assign raddr_v = {raddr2, raddr1, raddr0};
  assign {rdata2, rdata1, rdata0} = rdata_v;

  for (genvar g = 0; g < NRP; g++) begin : g_rp
    regfile_rport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rp (
      .ready (ready),
      .raddr (raddr_v[g]),
      .arr   (mem[raddr_v[g]]),
      .we0   (we0),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .we1   (we1),
      .waddr1(waddr1),
      .wdata1(wdata1),
      .rdata (rdata_v[g])
    );
  end
endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench for regfile_multi: one bypassing and one non-bypassing instance
// share stimulus; expected values go through a scoreboard queue.
module tb_regfile_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr0, raddr1, raddr2, waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        we0, we1, wr_drop_clr;
  logic [31:0] rdata0_b, rdata1_b, rdata2_b, rdata0_n, rdata1_n, rdata2_n;
  logic        ready_b, ready_n, wr_drop_b, wr_drop_n;

  logic [31:0] sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n;

  always #5 clk = ~clk;

  regfile_multi #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .rdata0(rdata0_b), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .ready(ready_b), .wr_drop(wr_drop_b), .wr_drop_clr(wr_drop_clr)
  );

  regfile_multi #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .rdata0(rdata0_n), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .ready(ready_n), .wr_drop(wr_drop_n), .wr_drop_clr(wr_drop_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready_b !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we0 = 1'b0; we1 = 1'b0; wr_drop_clr = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr0 = '0; raddr1 = '0; raddr2 = 5'd31;
    repeat (2) step();
    sb.push_back(0); chk("rst_ready", {31'b0, ready_b});
    sb.push_back(0); chk("rst_wr_drop", {31'b0, wr_drop_b});
    sb.push_back(0); chk("rst_rdata2", rdata2_b);

    // Sweep with a dropped write on edge 10
    rst_n = 1'b1;
    repeat (9) step();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55;
    step();
    we0 = 1'b0;
    sb.push_back(1); chk("drop_set", {31'b0, wr_drop_b});
    sb.push_back(0); chk("sweep_not_ready", {31'b0, ready_b});
    wait_ready(n);
    sb.push_back(32); chk("sweep_len", 32'(n + 10));
    sb.push_back(1); chk("drop_sticky", {31'b0, wr_drop_b});
    sb.push_back(1); chk("ready_nb", {31'b0, ready_n});
    raddr0 = 5'd0; raddr1 = 5'd7; raddr2 = 5'd30; #1;
    sb.push_back(0); chk("r0", rdata0_b);
    sb.push_back(0); chk("r7", rdata1_b);
    sb.push_back(2); chk("r30", rdata2_b);
    sb.push_back(2); chk("r30_nb", rdata2_n);
    raddr0 = 5'd31; raddr1 = 5'd3; #1;
    sb.push_back(4); chk("r31", rdata0_b);
    sb.push_back(0); chk("r3_dropped", rdata1_n);
    wr_drop_clr = 1'b1;
    step();
    wr_drop_clr = 1'b0;
    sb.push_back(0); chk("drop_clr", {31'b0, wr_drop_b});

    // Same-address dual write: port 1 wins
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA0000;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0000BBBB;
    raddr0 = 5'd5; #1;
    sb.push_back(32'h0000BBBB); chk("byp_conflict", rdata0_b);
    step();
    we0 = 1'b0; we1 = 1'b0; #1;
    sb.push_back(32'h0000BBBB); chk("r5_nb", rdata0_n);
    sb.push_back(32'h0000BBBB); chk("r5_b", rdata0_b);
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h66666666;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h77777777;
    step();
    we0 = 1'b0; we1 = 1'b0;
    raddr1 = 5'd6; raddr2 = 5'd7; #1;
    sb.push_back(32'h66666666); chk("r6", rdata1_n);
    sb.push_back(32'h77777777); chk("r7_wr", rdata2_n);

    // Bypass vs registered visibility
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678; raddr2 = 5'd9; #1;
    sb.push_back(32'h12345678); chk("byp_r9", rdata2_b);
    sb.push_back(0); chk("nobyp_r9_old", rdata2_n);
    step();
    we0 = 1'b0; #1;
    sb.push_back(32'h12345678); chk("r9_b", rdata2_b);
    sb.push_back(32'h12345678); chk("r9_nb", rdata2_n);

    // Zero register
    we0 = 1'b1; we1 = 1'b1; waddr0 = '0; waddr1 = '0;
    wdata0 = 32'hFFFFFFFF; wdata1 = 32'hFFFFFFFF; raddr0 = '0; #1;
    sb.push_back(0); chk("z_pre_b", rdata0_b);
    sb.push_back(0); chk("z_pre_nb", rdata0_n);
    step();
    we1 = 1'b0; #1;
    sb.push_back(0); chk("z_post_b", rdata0_b);
    sb.push_back(0); chk("z_post_nb", rdata0_n);
    step();
    we0 = 1'b0; #1;
    sb.push_back(0); chk("z_p0_nb", rdata0_n);
    sb.push_back(0); chk("run_no_drop", {31'b0, wr_drop_b});

    // Reset in RUN, then again mid-sweep
    raddr0 = 5'd31; #1;
    rst_n = 1'b0; #1;
    sb.push_back(0); chk("rst_async_ready", {31'b0, ready_b});
    sb.push_back(0); chk("rst_rd_forced", rdata0_b);
    step(); step();
    rst_n = 1'b1;
    repeat (20) step();
    rst_n = 1'b0; #1;
    sb.push_back(0); chk("mid_rst_ready", {31'b0, ready_b});
    step(); step();
    rst_n = 1'b1;
    wait_ready(n);
    sb.push_back(32); chk("resweep_len", 32'(n));
    raddr0 = 5'd5; raddr1 = 5'd31; raddr2 = 5'd30; #1;
    sb.push_back(0); chk("r5_recleared", rdata0_b);
    sb.push_back(4); chk("r31_re", rdata1_b);
    sb.push_back(2); chk("r30_re", rdata2_n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
